// File: rtl/seg_scan_ctrl_4dig_if.sv
// Control/status bundle between a display host and the 4-digit scan controller.
// Directions are named from the controller's side (_i into it, _o out of it).
interface seg_scan_ctrl_4dig_if;
    logic        en_i;
    logic        ld_i;
    logic [15:0] data_i;
    logic [3:0]  dp_i;
    logic        blank_lz_i;
    logic [1:0]  sel_o;
    logic [7:0]  segs_o;
    logic        busy_o;
    logic        frame_tick_o;

    modport master (
        output en_i, ld_i, data_i, dp_i, blank_lz_i,
        input  sel_o, segs_o, busy_o, frame_tick_o
    );

    modport slave (
        input  en_i, ld_i, data_i, dp_i, blank_lz_i,
        output sel_o, segs_o, busy_o, frame_tick_o
    );
endinterface

// File: rtl/seg_scan_ctrl_4dig.sv
// Scan controller for a 4-digit common-anode 7-segment display: frame-aligned
// double buffering, per-slot ghost blanking and optional leading-zero suppression.
module seg_scan_ctrl_4dig #(
    parameter int unsigned CNT_MAX   = 50000,
    parameter int unsigned BLANK_CYC = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    seg_scan_ctrl_4dig_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(CNT_MAX);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       sel_q, sel_d;
    logic [15:0]      act_data_q, act_data_d;
    logic [3:0]       act_dp_q, act_dp_d;
    logic [15:0]      pend_data_q, pend_data_d;
    logic [3:0]       pend_dp_q, pend_dp_d;
    logic             pend_q, pend_d;
    logic [7:0]       segs_q, segs_d;
    logic             tick_q, tick_d;

    logic             wrap;
    logic             boundary;
    logic             lz_blank;
    logic [3:0]       nib;
    logic [6:0]       glyph;

    // Active-low {G..A} pattern for one hex nibble.
    function automatic logic [6:0] hex_glyph(input logic [3:0] n);
        logic [6:0] g;
        case (n)
            4'h0: g = 7'h40;
            4'h1: g = 7'h79;
            4'h2: g = 7'h24;
            4'h3: g = 7'h30;
            4'h4: g = 7'h19;
            4'h5: g = 7'h12;
            4'h6: g = 7'h02;
            4'h7: g = 7'h78;
            4'h8: g = 7'h00;
            4'h9: g = 7'h10;
            4'hA: g = 7'h08;
            4'hB: g = 7'h03;
            4'hC: g = 7'h46;
            4'hD: g = 7'h21;
            4'hE: g = 7'h06;
            default: g = 7'h0E;
        endcase
        return g;
    endfunction

    always_comb begin
        cnt_d       = cnt_q;
        sel_d       = sel_q;
        act_data_d  = act_data_q;
        act_dp_d    = act_dp_q;
        pend_data_d = pend_data_q;
        pend_dp_d   = pend_dp_q;
        pend_d      = pend_q;
        tick_d      = 1'b0;
        segs_d      = 8'hFF;
        lz_blank    = 1'b0;

        wrap     = bus.en_i && (cnt_q == CNT_W'(CNT_MAX - 1));
        boundary = wrap && (sel_q == 2'd3);

        if (bus.en_i) begin
            cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
            if (wrap) begin
                sel_d = sel_q + 2'd1;
            end
        end
        tick_d = boundary;

        // While stopped the display is dark, so loads may land immediately.
        if (!bus.en_i || boundary) begin
            if (bus.ld_i) begin
                act_data_d = bus.data_i;
                act_dp_d   = bus.dp_i;
                pend_d     = 1'b0;
            end else if (pend_q) begin
                act_data_d = pend_data_q;
                act_dp_d   = pend_dp_q;
                pend_d     = 1'b0;
            end
        end else if (bus.ld_i) begin
            pend_data_d = bus.data_i;
            pend_dp_d   = bus.dp_i;
            pend_d      = 1'b1;
        end

        // Glyph is derived from next-state values so SEGS lines up with SEL.
        nib = act_data_d[{sel_d, 2'b00} +: 4];
        case (sel_d)
            2'd1:    lz_blank = (act_data_d[15:4]  == 12'd0);
            2'd2:    lz_blank = (act_data_d[15:8]  == 8'd0);
            2'd3:    lz_blank = (act_data_d[15:12] == 4'd0);
            default: lz_blank = 1'b0;
        endcase
        lz_blank = lz_blank && bus.blank_lz_i;
        glyph    = lz_blank ? 7'h7F : hex_glyph(nib);

        if (bus.en_i && (cnt_d >= CNT_W'(BLANK_CYC))) begin
            segs_d = {~act_dp_d[sel_d], glyph};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q       <= '0;
            sel_q       <= 2'd0;
            act_data_q  <= 16'd0;
            act_dp_q    <= 4'd0;
            pend_data_q <= 16'd0;
            pend_dp_q   <= 4'd0;
            pend_q      <= 1'b0;
            segs_q      <= 8'hFF;
            tick_q      <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            sel_q       <= sel_d;
            act_data_q  <= act_data_d;
            act_dp_q    <= act_dp_d;
            pend_data_q <= pend_data_d;
            pend_dp_q   <= pend_dp_d;
            pend_q      <= pend_d;
            segs_q      <= segs_d;
            tick_q      <= tick_d;
        end
    end

    assign bus.sel_o        = sel_q;
    assign bus.segs_o       = segs_q;
    assign bus.busy_o       = pend_q;
    assign bus.frame_tick_o = tick_q;
endmodule

// File: tb/tb_seg_scan_ctrl_4dig.sv
// Scoreboard bench for seg_scan_ctrl_4dig: the driver queues the expected
// outputs for each cycle, a negedge monitor pops and compares them.
module tb_seg_scan_ctrl_4dig;
    localparam int unsigned CNT_MAX   = 4;
    localparam int unsigned BLANK_CYC = 1;

    typedef struct {
        int unsigned cyc;
        int unsigned phase;
        logic [1:0]  sel;
        logic [7:0]  segs;
        logic        busy;
        logic        tick;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    seg_scan_ctrl_4dig_if bus ();

    seg_scan_ctrl_4dig #(
        .CNT_MAX  (CNT_MAX),
        .BLANK_CYC(BLANK_CYC)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    int unsigned cyc      = 0;
    exp_t        q[$];

    // Expected-display bookkeeping: slot position plus hand-computed glyph tables.
    int unsigned p_cnt, p_sel, phase;
    logic        p_tick, b_pend;
    logic [7:0]  act_dig[4];
    logic [7:0]  pend_dig[4];
    logic [7:0]  ld_dig[4];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin : monitor
        exp_t e;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            checks++;
            if (e.cyc != cyc || bus.sel_o !== e.sel || bus.segs_o !== e.segs ||
                bus.busy_o !== e.busy || bus.frame_tick_o !== e.tick) begin
                failures++;
                $display("FAIL phase%0d cyc=%0d (tag %0d): got sel=%0d segs=%h busy=%b tick=%b, want sel=%0d segs=%h busy=%b tick=%b",
                         e.phase, cyc, e.cyc, bus.sel_o, bus.segs_o, bus.busy_o, bus.frame_tick_o,
                         e.sel, e.segs, e.busy, e.tick);
            end
        end
    end

    // One clock edge; update the expected position/buffers and queue the expectation.
    task automatic step();
        logic en_s, ld_s, rst_s, bnd;
        exp_t e;
        en_s  = bus.en_i;
        ld_s  = bus.ld_i;
        rst_s = rst;
        @(posedge clk);
        #1;
        if (rst_s) begin
            p_cnt  = 0;
            p_sel  = 0;
            p_tick = 1'b0;
            b_pend = 1'b0;
        end else begin
            bnd = en_s && (p_cnt == CNT_MAX - 1) && (p_sel == 3);
            if (en_s) begin
                if (p_cnt == CNT_MAX - 1) begin
                    p_cnt = 0;
                    p_sel = (p_sel + 1) % 4;
                end else begin
                    p_cnt++;
                end
            end
            p_tick = bnd;
            if (!en_s || bnd) begin
                if (ld_s) begin
                    act_dig = ld_dig;
                    b_pend  = 1'b0;
                end else if (b_pend) begin
                    act_dig = pend_dig;
                    b_pend  = 1'b0;
                end
            end else if (ld_s) begin
                pend_dig = ld_dig;
                b_pend   = 1'b1;
            end
        end
        e.cyc   = cyc;
        e.phase = phase;
        e.sel   = 2'(p_sel);
        e.segs  = (rst_s || !en_s || p_cnt < BLANK_CYC) ? 8'hFF : act_dig[p_sel];
        e.busy  = b_pend;
        e.tick  = p_tick;
        q.push_back(e);
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] dp,
                           input logic [7:0] g0, input logic [7:0] g1,
                           input logic [7:0] g2, input logic [7:0] g3);
        bus.ld_i   = 1'b1;
        bus.data_i = d;
        bus.dp_i   = dp;
        ld_dig     = '{g0, g1, g2, g3};
        step();
        bus.ld_i   = 1'b0;
    endtask

    task automatic goto_pos(input int unsigned s, input int unsigned c);
        for (int i = 0; i < 64 && !(p_sel == s && p_cnt == c); i++) step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst            = 1'b1;
        bus.en_i       = 1'b0;
        bus.ld_i       = 1'b0;
        bus.data_i     = 16'd0;
        bus.dp_i       = 4'd0;
        bus.blank_lz_i = 1'b0;
        p_cnt  = 0;
        p_sel  = 0;
        p_tick = 1'b0;
        b_pend = 1'b0;
        act_dig  = '{8'hC0, 8'hC0, 8'hC0, 8'hC0};
        pend_dig = act_dig;
        ld_dig   = act_dig;
        phase    = 1;
        #1;

        // Reset, then free-running scan over more than one frame.
        step();
        step();
        rst      = 1'b0;
        bus.en_i = 1'b1;
        repeat (20) step();

        // Mid-frame load shows only after the boundary.
        phase = 2;
        do_load(16'h12AF, 4'b0100, 8'h8E, 8'h88, 8'h24, 8'hF9);
        repeat (32) step();

        // Leading-zero suppression on, then off.
        phase = 3;
        bus.blank_lz_i = 1'b1;
        do_load(16'h0050, 4'b0000, 8'hC0, 8'h92, 8'hFF, 8'hFF);
        repeat (36) step();
        bus.blank_lz_i = 1'b0;
        act_dig = '{8'hC0, 8'h92, 8'hC0, 8'hC0};
        repeat (16) step();

        // Last load wins; load on the boundary edge goes straight to active.
        phase = 4;
        goto_pos(0, 1);
        do_load(16'h1111, 4'b0000, 8'hF9, 8'hF9, 8'hF9, 8'hF9);
        repeat (2) step();
        do_load(16'h2222, 4'b0000, 8'hA4, 8'hA4, 8'hA4, 8'hA4);
        repeat (24) step();
        goto_pos(3, CNT_MAX - 1);
        do_load(16'h3333, 4'b0000, 8'hB0, 8'hB0, 8'hB0, 8'hB0);
        repeat (8) step();

        // Hold with EN=0: pending transfers, direct load, resume without slip.
        phase = 5;
        goto_pos(2, 0);
        do_load(16'h89AB, 4'b0000, 8'h83, 8'h88, 8'h90, 8'h80);
        bus.en_i = 1'b0;
        repeat (4) step();
        do_load(16'h4567, 4'b1111, 8'h78, 8'h02, 8'h12, 8'h19);
        repeat (5) step();
        bus.en_i = 1'b1;
        repeat (24) step();

        // Reset with a load pending discards it.
        phase = 6;
        goto_pos(3, 0);
        do_load(16'h1234, 4'b0000, 8'h99, 8'hB0, 8'hA4, 8'hF9);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        act_dig = '{8'hC0, 8'hC0, 8'hC0, 8'hC0};
        repeat (8) step();

        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d unconsumed expectations, want 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
